// File: rtl/attr_pkg.sv
// Shared constants, FSM state type and quadrant helper for the attribute palette fetch block.
package attr_pkg;

  localparam int ATTR_BYTES = 64;
  localparam int ATTR_AW    = 6;
  localparam int TILE_W     = 5;
  localparam int PAL_W      = 2;

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } attr_state_t;

  // Quadrant of a tile inside its 32x32-pixel attribute cell: {row bit1, col bit1}.
  function automatic logic [1:0] attr_quad(input logic [TILE_W-1:0] col,
                                           input logic [TILE_W-1:0] row);
    return {row[1], col[1]};
  endfunction

endpackage

// File: rtl/attr_ram.sv
// Simple dual-port (one write, one read) synchronous RAM holding the attribute bytes.
// Contents are not reset; the owner initialises them with a write sweep.
module attr_ram #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Write port: one byte per clock when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: registered read data, held when not enabled.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/attr_palette_fetch.sv
// Writable attribute-table store with a 2-stage tile -> palette-selector lookup pipeline.
// Build option ATTR_RDBACK_EN adds a raw-byte CPU read-back port sharing the RAM read port.
module attr_palette_fetch
  import attr_pkg::*;
#(
  parameter int         NUM_TABLES = 2,
  parameter logic [7:0] INIT_VAL   = 8'h00,
  parameter int         TS_W       = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_req,
  output logic               busy,
  input  logic               rd_req,
  input  logic [TS_W-1:0]    rd_tbl,
  input  logic [TILE_W-1:0]  rd_col,
  input  logic [TILE_W-1:0]  rd_row,
  output logic               rd_vld,
  output logic [PAL_W-1:0]   rd_pal,
  input  logic               wr_en,
  input  logic [TS_W-1:0]    wr_tbl,
  input  logic [ATTR_AW-1:0] wr_addr,
`ifdef ATTR_RDBACK_EN
  input  logic               cpu_rd_en,
  input  logic [TS_W-1:0]    cpu_rd_tbl,
  input  logic [ATTR_AW-1:0] cpu_rd_addr,
  output logic [7:0]         cpu_rd_data,
  output logic               cpu_rd_vld,
`endif
  input  logic [7:0]         wr_data
);

  localparam int DEPTH = NUM_TABLES * ATTR_BYTES;
  localparam int AW    = TS_W + ATTR_AW;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  attr_state_t   state;
  logic [AW-1:0] cnt;
  logic          idle;

  logic          cpu_acc;
  logic          rd_acc;
  logic [AW-1:0] look_addr;
  logic [AW-1:0] ram_raddr;
  logic          raddr_ok;
  logic          ram_re;

  logic          user_we;
  logic [AW-1:0] user_waddr;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;
  logic          byp;

  logic          s1_vld;
  logic          s1_zero;
  logic [1:0]    s1_q;
  logic          s1_byp;
  logic [7:0]    s1_bdata;
  logic [7:0]    s1_byte;

  // Table indices at or above NUM_TABLES have no storage behind them.
  function automatic logic tbl_ok(input logic [TS_W-1:0] t);
    return (int'(t) < NUM_TABLES);
  endfunction

  assign idle      = (state == ST_IDLE);
  assign look_addr = {rd_tbl, rd_row[4:2], rd_col[4:2]};

`ifdef ATTR_RDBACK_EN
  assign cpu_acc   = cpu_rd_en && idle;
  assign ram_raddr = cpu_acc ? {cpu_rd_tbl, cpu_rd_addr} : look_addr;
  assign raddr_ok  = cpu_acc ? tbl_ok(cpu_rd_tbl) : tbl_ok(rd_tbl);
`else
  assign cpu_acc   = 1'b0;
  assign ram_raddr = look_addr;
  assign raddr_ok  = tbl_ok(rd_tbl);
`endif

  // A CPU read owns the read port for its clock; the lookup it displaces is dropped.
  assign rd_acc = rd_req && idle && !cpu_acc;
  assign ram_re = (rd_acc || cpu_acc) && raddr_ok;

  assign user_we    = wr_en && idle && tbl_ok(wr_tbl);
  assign user_waddr = {wr_tbl, wr_addr};
  assign ram_we     = !idle || user_we;
  assign ram_waddr  = idle ? user_waddr : cnt;
  assign ram_wdata  = idle ? wr_data : INIT_VAL;

  // Same-clock write to the byte being read: hand the new data forward.
  assign byp = user_we && (user_waddr == ram_raddr);

  attr_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Init sweep FSM: rewrite every entry with INIT_VAL, restartable by clr_req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          if (clr_req) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (clr_req) begin
            state <= ST_INIT;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_INIT;
          busy  <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Stage 1: RAM read in flight; capture quadrant, force-zero and bypass information.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_zero  <= 1'b0;
      s1_q     <= 2'b00;
      s1_byp   <= 1'b0;
      s1_bdata <= 8'h00;
    end else begin
      s1_vld   <= rd_acc;
      s1_zero  <= !raddr_ok || (!cpu_acc && (rd_row[4:1] == 4'b1111));
      s1_q     <= attr_quad(rd_col, rd_row);
      s1_byp   <= byp;
      s1_bdata <= wr_data;
    end
  end

  assign s1_byte = s1_zero ? 8'h00 : (s1_byp ? s1_bdata : ram_rdata);

  // Stage 2: select the quadrant's 2 bits; rd_pal holds between valid results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld <= 1'b0;
      rd_pal <= '0;
    end else begin
      rd_vld <= s1_vld;
      if (s1_vld) rd_pal <= s1_byte[{s1_q, 1'b0} +: PAL_W];
    end
  end

`ifdef ATTR_RDBACK_EN
  // CPU read-back valid, one clock after an accepted cpu_rd_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cpu_rd_vld <= 1'b0;
    else        cpu_rd_vld <= cpu_acc;
  end

  assign cpu_rd_data = cpu_rd_vld ? s1_byte : 8'h00;
`endif

endmodule
